result_display: RTL

RESULT_DISPLAY -- requirements
Module: result_display

---
 rtl/display_pkg.sv | 47 ++++
 rtl/bin2bcd_serial.sv | 76 +++++++
 rtl/result_display.sv | 104 ++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the calculator result display.
package display_pkg;

   // Serial binary-to-BCD converter states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LOAD  = 2'd2
   } conv_state_e;

   localparam int NUM_DIGITS = 4;
   localparam int BIN_BITS   = 9;
   localparam int BCD_BITS   = 12;

   // Active-low cathode patterns, bit order g..a.
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Decode one BCD digit; non-decimal codes show nothing.
   function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
      logic [6:0] pat;
      case (digit)
         4'd0:    pat = SEG_0;
         4'd1:    pat = SEG_1;
         4'd2:    pat = SEG_2;
         4'd3:    pat = SEG_3;
         4'd4:    pat = SEG_4;
         4'd5:    pat = SEG_5;
         4'd6:    pat = SEG_6;
         4'd7:    pat = SEG_7;
         4'd8:    pat = SEG_8;
         4'd9:    pat = SEG_9;
         default: pat = SEG_BLANK;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Sequential double-dabble converter: 9-bit binary to three BCD digits,
// one iteration per clock, result valid while done_o is high.
module bin2bcd_serial
   import display_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                start_i,
   input  logic [BIN_BITS-1:0] bin_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [BCD_BITS-1:0] bcd_o
);

   localparam logic [3:0] LAST_ITER = 4'(BIN_BITS - 1);

   conv_state_e         state_q, state_d;
   logic [BIN_BITS-1:0] sample_q, sample_d;
   logic [BCD_BITS-1:0] bcd_q, bcd_d, bcd_adj;
   logic [3:0]          count_q, count_d;

   // State, shift register and iteration count.
   // NOTE: async reset appears in the sensitivity list; state uses <= only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         sample_q <= '0;
         bcd_q    <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         sample_q <= sample_d;
         bcd_q    <= bcd_d;
         count_q  <= count_d;
      end
   end

   // Add-3 correction of every BCD nibble that would overflow on the shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < BCD_BITS / 4; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   // Next-state logic: capture on start, nine shift iterations, one load cycle.
   // NOTE: every variable gets a default first so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      sample_d = sample_q;
      bcd_d    = bcd_q;
      count_d  = count_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               sample_d = bin_i;
               bcd_d    = '0;
               count_d  = '0;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            {bcd_d, sample_d} = {bcd_adj, sample_q} << 1;
            count_d           = count_q + 4'd1;
            if (count_q == LAST_ITER) state_d = LOAD;
         end
         LOAD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy_o = (state_q != IDLE);
   assign done_o = (state_q == LOAD);
   assign bcd_o  = bcd_q;

endmodule

// File: rtl/result_display.sv
// Shows the calculator result in decimal on a 4-digit multiplexed
// seven-segment display, with leading-zero blanking and slot 3 always off.
module result_display
   import display_pkg::*;
#(
   parameter int REFRESH_BITS = 20
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [BIN_BITS-1:0]   result,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [NUM_DIGITS-1:0] an,
   output logic                  busy
);

   logic [BIN_BITS-1:0]     captured_q, captured_d;
   logic [3:0]              ones_q, ones_d, tens_q, tens_d, hund_q, hund_d;
   logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
   logic [6:0]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    conv_busy, conv_done, conv_start;
   logic [BCD_BITS-1:0]     conv_bcd;
   logic [1:0]              slot;

   // A new conversion starts only while the converter is idle; changes seen
   // during a conversion are picked up by the compare once it returns.
   assign conv_start = !conv_busy && (result != captured_q);

   bin2bcd_serial u_bin2bcd (
      .clk     (clk),
      .reset   (reset),
      .start_i (conv_start),
      .bin_i   (result),
      .busy_o  (conv_busy),
      .done_o  (conv_done),
      .bcd_o   (conv_bcd)
   );

   // Change detect, digit latching and free-running refresh counter.
   always_comb begin
      captured_d = conv_start ? result : captured_q;
      ones_d     = conv_done ? conv_bcd[3:0]  : ones_q;
      tens_d     = conv_done ? conv_bcd[7:4]  : tens_q;
      hund_d     = conv_done ? conv_bcd[11:8] : hund_q;
      refresh_d  = refresh_q + 1'b1;
   end

   // Pattern for the current slot; hundreds and tens blank as leading zeros.
   always_comb begin
      slot  = refresh_q[REFRESH_BITS-1 -: 2];
      an_d  = '1;
      seg_d = SEG_BLANK;
      case (slot)
         2'd0: begin
            an_d  = ~(NUM_DIGITS'(1) << slot);
            seg_d = seg_pattern(ones_q);
         end
         2'd1: begin
            if ((hund_q != 4'd0) || (tens_q != 4'd0)) begin
               an_d  = ~(NUM_DIGITS'(1) << slot);
               seg_d = seg_pattern(tens_q);
            end
         end
         2'd2: begin
            if (hund_q != 4'd0) begin
               an_d  = ~(NUM_DIGITS'(1) << slot);
               seg_d = seg_pattern(hund_q);
            end
         end
         default: begin
            an_d  = '1;
            seg_d = SEG_BLANK;
         end
      endcase
   end

   // Registered display state so anode/cathode changes are glitch-free.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         captured_q <= '0;
         ones_q     <= '0;
         tens_q     <= '0;
         hund_q     <= '0;
         refresh_q  <= '0;
         seg_q      <= SEG_0;
         an_q       <= 4'b1110;
      end else begin
         captured_q <= captured_d;
         ones_q     <= ones_d;
         tens_q     <= tens_d;
         hund_q     <= hund_d;
         refresh_q  <= refresh_d;
         seg_q      <= seg_d;
         an_q       <= an_d;
      end
   end

   assign seg  = seg_q;
   assign an   = an_q;
   assign dp   = 1'b1;
   assign busy = conv_busy;

endmodule
